// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and instruction ROM (slave).
interface pc_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    localparam int unsigned INSTR_W = 32;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetcher: one outstanding imem request, presents
// (pc, instr) to decode, handles redirects, misalignment and a fetch counter.
module pc_fetch_unit #(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned    PC_STEP      = 4
) (
    input  logic                clk,
    input  logic                rst,
    pc_fetch_unit_if.master     imem,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [31:0]         out_instr,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_target,
    output logic                misalign_err,
    output logic [XLEN-1:0]     misalign_addr,
    output logic [XLEN-1:0]     fetch_count
);
    localparam int unsigned INSTR_W = 32;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_HALT
    } state_e;

    state_e               state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic                 req_valid_q, req_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic [XLEN-1:0]      out_pc_q, out_pc_d;
    logic [INSTR_W-1:0]   out_instr_q, out_instr_d;
    logic                 misalign_err_q, misalign_err_d;
    logic [XLEN-1:0]      misalign_addr_q, misalign_addr_d;
    logic [XLEN-1:0]      fetch_count_q, fetch_count_d;

    logic req_hs_c;
    logic rsp_owed_c;

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        out_pc_d        = out_pc_q;
        out_instr_d     = out_instr_q;
        fetch_count_d   = fetch_count_q;
        misalign_err_d  = 1'b0;
        misalign_addr_d = misalign_addr_q;

        req_hs_c   = req_valid_q && imem.imem_req_ready;
        // A response is still owed after this cycle if a request is in flight and not answered now
        rsp_owed_c = (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem.imem_rsp_valid)
                   || ((state_q == S_REQ) && req_hs_c);

        unique case (state_q)
            S_REQ: begin
                if (req_hs_c) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_rsp_valid) begin
                    out_pc_d    = pc_q;
                    out_instr_d = imem.imem_rsp_data;
                    pc_d        = pc_q + XLEN'(PC_STEP);
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    fetch_count_d = fetch_count_q + XLEN'(1);
                    state_d       = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem.imem_rsp_valid) state_d = S_REQ;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // Redirect overrides the normal flow and squashes any held instruction
        if (redirect_valid && (state_q != S_HALT)) begin
            pc_d          = pc_q;
            out_pc_d      = out_pc_q;
            out_instr_d   = out_instr_q;
            fetch_count_d = fetch_count_q;
            if (redirect_target[1:0] != 2'b00) begin
                misalign_err_d  = 1'b1;
                misalign_addr_d = redirect_target;
                state_d         = S_HALT;
            end else begin
                pc_d    = redirect_target;
                state_d = rsp_owed_c ? S_DRAIN : S_REQ;
            end
        end

        req_valid_d = (state_d == S_REQ);
        out_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_REQ;
            pc_q            <= RESET_VECTOR;
            req_valid_q     <= 1'b1;
            out_valid_q     <= 1'b0;
            out_pc_q        <= '0;
            out_instr_q     <= '0;
            misalign_err_q  <= 1'b0;
            misalign_addr_q <= '0;
            fetch_count_q   <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            req_valid_q     <= req_valid_d;
            out_valid_q     <= out_valid_d;
            out_pc_q        <= out_pc_d;
            out_instr_q     <= out_instr_d;
            misalign_err_q  <= misalign_err_d;
            misalign_addr_q <= misalign_addr_d;
            fetch_count_q   <= fetch_count_d;
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_req_addr  = pc_q;
    assign out_valid           = out_valid_q;
    assign out_pc              = out_pc_q;
    assign out_instr           = out_instr_q;
    assign misalign_err        = misalign_err_q;
    assign misalign_addr       = misalign_addr_q;
    assign fetch_count         = fetch_count_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: ROM model with programmable wait states,
// expected request addresses and delivered (pc, instr) pairs checked by monitors.
module tb_pc_fetch_unit;
    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic            clk;
    logic            rst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            misalign_err;
    logic [XLEN-1:0] misalign_addr;
    logic [XLEN-1:0] fetch_count;

    pc_fetch_unit_if #(.XLEN(XLEN)) imem_bus ();

    pc_fetch_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (32'h0000_0000),
        .PC_STEP      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem            (imem_bus),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .misalign_err    (misalign_err),
        .misalign_addr   (misalign_addr),
        .fetch_count     (fetch_count)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          ready_low = 0;
    int          rsp_lat = 1;
    logic [31:0] exp_addr_q[$];
    out_t        exp_out_q[$];
    int          hs_cyc_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ROM model: stalls ready for ready_low cycles, answers rsp_lat cycles after acceptance
    initial begin : rom_model
        logic        pending;
        int          stall;
        int          cnt;
        logic [31:0] paddr;
        pending = 1'b0;
        stall   = 0;
        cnt     = 0;
        paddr   = '0;
        imem_bus.imem_req_ready = 1'b0;
        imem_bus.imem_rsp_valid = 1'b0;
        imem_bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            imem_bus.imem_rsp_valid = 1'b0;
            imem_bus.imem_req_ready = 1'b0;
            if (rst) begin
                pending = 1'b0;
                stall   = 0;
            end else begin
                if (pending) begin
                    if (cnt == 0) begin
                        imem_bus.imem_rsp_valid = 1'b1;
                        imem_bus.imem_rsp_data  = rom(paddr);
                        pending = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (imem_bus.imem_req_valid) begin
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL req_unexpected: got request addr 0x%0h, expected no request (cycle %0d)",
                                 imem_bus.imem_req_addr, cyc);
                    end else begin
                        check("req_addr", imem_bus.imem_req_addr, exp_addr_q[0]);
                    end
                    if (stall < ready_low) begin
                        stall++;
                    end else begin
                        imem_bus.imem_req_ready = 1'b1;
                        stall   = 0;
                        pending = 1'b1;
                        paddr   = imem_bus.imem_req_addr;
                        cnt     = rsp_lat - 1;
                        if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
                    end
                end
            end
        end
    end

    // Output monitor: every unsquashed handshake must match the next expected pair
    initial begin : out_monitor
        out_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready && !redirect_valid) begin
                hs_cyc_q.push_back(cyc);
                if (exp_out_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_unexpected: got pc 0x%0h instr 0x%0h, expected no output (cycle %0d)",
                             out_pc, out_instr, cyc);
                end else begin
                    e = exp_out_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", out_instr, e.instr);
                end
            end
        end
    end

    task automatic wait_fc(input logic [31:0] target, input int budget, input string name);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (fetch_count == target);
        end
        check(name, fetch_count, target);
    endtask

    task automatic wait_valid(input int budget, input string name);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (out_valid == 1'b1);
        end
        check(name, out_valid, 1);
    endtask

    task automatic wait_req_low(input int budget, input string name);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            done = (imem_bus.imem_req_valid == 1'b0);
        end
        check(name, imem_bus.imem_req_valid, 0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_out_left"}, exp_out_q.size(), 0);
        check({tag, "_addr_left"}, exp_addr_q.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_pc"}, out_pc, 0);
        check({tag, "_out_instr"}, out_instr, 0);
        check({tag, "_misalign_err"}, misalign_err, 0);
        check({tag, "_misalign_addr"}, misalign_addr, 0);
        check({tag, "_fetch_count"}, fetch_count, 0);
        check({tag, "_req_valid"}, imem_bus.imem_req_valid, 1);
        check({tag, "_req_addr"}, imem_bus.imem_req_addr, 32'h0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst             = 1'b1;
        out_ready       = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        tick();
        tick();
        check_reset_state("rst0");

        // Sequential fetch: zero-wait, then out_ready stall, then wait-state memory
        for (int k = 0; k < 7; k++) exp_addr_q.push_back(32'(4 * k));
        for (int k = 0; k < 6; k++) exp_out_q.push_back('{pc: 32'(4 * k), instr: 32'h1000_0000 + 32'(k)});
        ready_low = 0;
        rsp_lat   = 1;
        out_ready = 1'b1;
        rst       = 1'b0;
        wait_fc(32'd3, 40, "seq_fc3");
        out_ready = 1'b0;
        if (hs_cyc_q.size() >= 3) begin
            check("spacing01", hs_cyc_q[1] - hs_cyc_q[0], 3);
            check("spacing12", hs_cyc_q[2] - hs_cyc_q[1], 3);
        end else begin
            check("spacing_count", hs_cyc_q.size(), 3);
        end

        wait_valid(20, "hold_valid");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_out_valid", out_valid, 1);
            check("hold_out_pc", out_pc, 32'd12);
            check("hold_out_instr", out_instr, 32'h1000_0003);
            check("hold_no_req", imem_bus.imem_req_valid, 0);
            check("hold_fc", fetch_count, 32'd3);
        end
        ready_low = 2;
        rsp_lat   = 3;
        out_ready = 1'b1;
        wait_fc(32'd4, 5, "hold_release_fc4");
        wait_fc(32'd6, 60, "wait_state_fc6");
        out_ready = 1'b0;
        wait_valid(40, "ws_last_valid");
        check("ws_last_pc", out_pc, 32'd24);
        check("ws_last_instr", out_instr, 32'h1000_0006);
        check_drained("phaseA");

        // Redirect to 0x40 while a response is outstanding
        rst = 1'b1;
        tick();
        tick();
        exp_addr_q.delete();
        exp_out_q.delete();
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h40);
        exp_addr_q.push_back(32'h44);
        exp_out_q.push_back('{pc: 32'h40, instr: 32'h1000_0010});
        ready_low = 0;
        rsp_lat   = 3;
        out_ready = 1'b1;
        rst       = 1'b0;
        wait_req_low(20, "redir_in_wait");
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("drain_no_req", imem_bus.imem_req_valid, 0);
        check("drain_no_valid", out_valid, 0);
        wait_fc(32'd1, 40, "redir_fc1");
        out_ready = 1'b0;
        wait_valid(40, "redir_next_valid");
        check("redir_next_pc", out_pc, 32'h44);
        check("redir_next_instr", out_instr, 32'h1000_0011);

        // Misaligned redirect in HOLD with out_ready high
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        out_ready       = 1'b1;
        tick();
        redirect_valid = 1'b0;
        check("mis_err_pulse", misalign_err, 1);
        check("mis_addr", misalign_addr, 32'h42);
        check("mis_out_valid", out_valid, 0);
        check("mis_fc", fetch_count, 32'd1);
        check("mis_no_req", imem_bus.imem_req_valid, 0);
        tick();
        check("mis_err_cleared", misalign_err, 0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h80;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("halt_no_req", imem_bus.imem_req_valid, 0);
            check("halt_no_valid", out_valid, 0);
        end
        check("halt_mis_addr", misalign_addr, 32'h42);
        check("halt_fc", fetch_count, 32'd1);
        check_drained("phaseB");

        // Reset out of HALT, then reset in the middle of WAIT
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        check_reset_state("rst_halt");
        exp_addr_q.delete();
        exp_out_q.delete();
        exp_addr_q.push_back(32'h0);
        rsp_lat = 2;
        rst     = 1'b0;
        wait_req_low(20, "rst_mid_wait_enter");
        rst = 1'b1;
        tick();
        check("rstw_req_valid", imem_bus.imem_req_valid, 1);
        check("rstw_req_addr", imem_bus.imem_req_addr, 32'h0);
        check("rstw_out_valid", out_valid, 0);
        check("rstw_fc", fetch_count, 32'd0);
        check_drained("rstw");
        exp_addr_q.push_back(32'h0);
        exp_addr_q.push_back(32'h4);
        exp_out_q.push_back('{pc: 32'h0, instr: 32'h1000_0000});
        out_ready = 1'b1;
        rst       = 1'b0;
        wait_fc(32'd1, 30, "restart_fc1");
        out_ready = 1'b0;
        wait_valid(30, "restart_next_valid");
        check("restart_next_pc", out_pc, 32'h4);
        check("restart_next_instr", out_instr, 32'h1000_0001);
        check_drained("phaseC");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised successor to the free-running PC register: owns the PC and fetches instructions over a valid/ready instruction-memory interface that tolerates wait states.
- Presents (pc, instr) pairs to decode with a valid/ready handshake.
- Accepts branch/jump redirects from execute, flags misaligned targets, and counts delivered instructions.
- Sits between the core's control/execute logic and instruction ROM; replaces direct PC-to-ROM wiring.

Parameters:
- XLEN, 32, width of PC, addresses and fetch counter.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response data valid; exactly one response per accepted request, at least 1 cycle after acceptance.
- imem_rsp_data  in  32  fetched instruction.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts instruction.
- out_pc  out  XLEN  PC of presented instruction.
- out_instr  out  32  presented instruction.
- redirect_valid  in  1  take branch/jump this cycle.
- redirect_target  in  XLEN  new PC.
- misalign_err  out  1  one-cycle pulse: redirect target[1:0] != 0.
- misalign_addr  out  XLEN  offending target, held until reset.
- fetch_count  out  XLEN  number of out_valid&&out_ready handshakes, wraps modulo 2^XLEN.

Behaviour:
- Reset (rst=1 at posedge, highest priority, also mid-transaction):
  - pc=RESET_VECTOR; state=REQ.
  - out_valid=0, out_pc=0, out_instr=0, misalign_err=0, misalign_addr=0, fetch_count=0.
  - Any in-flight response is not tracked; memory is reset alongside.
- FSM states: REQ, WAIT, HOLD, DRAIN, HALT.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_valid&&imem_req_ready, go to WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid, register out_pc=pc and out_instr=imem_rsp_data, set out_valid=1 next cycle, pc<=pc+PC_STEP (wraps), go to HOLD.
- HOLD:
  - out_valid=1; out_pc and out_instr are stable.
  - On out_ready: out_valid<=0, fetch_count++, go to REQ.
- DRAIN:
  - imem_req_valid=0; wait for the one outstanding response and discard it, then go to REQ.
  - The response is never presented and never counted.
- HALT:
  - imem_req_valid=0, out_valid=0; exit only via rst.
- Latency and throughput: with a zero-wait memory (ready=1, response 1 cycle after acceptance), a request accepted in cycle N yields out_valid in cycle N+2. Peak rate is 1 instruction per 3 cycles.
- imem_req_addr is always pc and is held stable while imem_req_valid=1 and ready=0.
- Redirect (redirect_valid=1, below rst in priority, evaluated every cycle in REQ/WAIT/HOLD/DRAIN), aligned target:
  - pc<=redirect_target; out_valid<=0 (a HOLD instruction is squashed, not counted, even if out_ready=1 that cycle).
  - Next state is DRAIN if a response is still owed after this cycle. That covers two cases: state WAIT without imem_rsp_valid this cycle, or REQ with request handshake this cycle.
  - Otherwise next state is REQ. A response arriving in the redirect cycle is discarded.
  - Redirect in DRAIN: update pc and stay in DRAIN, unless the response arrives this cycle, in which case go to REQ.
- Redirect with misaligned target (target[1:0] != 0):
  - misalign_err=1 for one cycle; misalign_addr<=target; out_valid<=0; go to HALT.
  - If a response is owed, it is ignored in HALT.
- Redirect in HALT is ignored.
- fetch_count increments only on an unsquashed HOLD handshake.

Test Plan:
- Reset, zero-wait ROM where word k = 0x1000_0000+k, out_ready=1 → imem_req_addr 0,4,8,...; out_pc/out_instr (0,0x10000000), (4,0x10000001), (8,0x10000002) at 3-cycle spacing; fetch_count=3 after three handshakes.
- Memory with req_ready low 2 cycles and response delayed 3 cycles → addr held stable; single out_valid per request, correct data; no duplicate or lost instructions.
- out_ready low 5 cycles in HOLD → out_pc/out_instr unchanged, no new request issued, fetch_count unchanged until the handshake.
- redirect_target=0x40 while in WAIT, response arriving 2 cycles later → response discarded (DRAIN); next request addr=0x40; first presented out_pc=0x40.
- redirect_target=0x42 while in HOLD with out_ready=1 → misalign_err pulses once, misalign_addr=0x42, out_valid=0, no further requests, fetch_count not incremented; after rst, fetch restarts at RESET_VECTOR with misalign_addr=0.
- rst asserted mid-WAIT → next cycle imem_req_valid=1, addr=RESET_VECTOR, out_valid=0, fetch_count=0.
